// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with Mealy/registered flags and saturating match count
module seq_detector_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             x,
    input  logic             ovl,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic             y_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              y_q_q, y_q_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  window;
    logic              full;
    logic              match;

    // The candidate word is the stored history with the live bit appended as LSB.
    assign window = {hist_q, x};
    assign full   = (fill_q == FILL_MAX);
    assign match  = en & ~pat_load & full & (window == pat_q);

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (en) begin
            hist_d = window[PAT_W-2:0];
            if (match && !ovl) begin
                fill_d = '0;
            end else if (!full) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_comb begin
        y_q_d = match;
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            y_q_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q_q  <= y_q_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y         = match;
    assign y_q       = y_q_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed and random checks of seq_detector_param against a stream-history model
module tb_seq_detector_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        x = 1'b0;
    logic        ovl = 1'b1;
    logic        pat_load = 1'b0;
    logic [31:0] pat_in = '0;
    logic        cnt_clr = 1'b0;

    logic       y_a, yq_a, y_b, yq_b, y_c, yq_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .ovl(ovl), .pat_load(pat_load),
        .pat_in(pat_in[3:0]), .cnt_clr(cnt_clr), .y(y_a), .y_q(yq_a), .match_cnt(cnt_a));

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .ovl(ovl), .pat_load(pat_load),
        .pat_in(pat_in[3:0]), .cnt_clr(cnt_clr), .y(y_b), .y_q(yq_b), .match_cnt(cnt_b));

    seq_detector_param #(.PAT_W(8), .PATTERN(8'hA5), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .ovl(ovl), .pat_load(pat_load),
        .pat_in(pat_in[7:0]), .cnt_clr(cnt_clr), .y(y_c), .y_q(yq_c), .match_cnt(cnt_c));

    int ncmp = 0;
    int nfail = 0;

    // Model: every accepted bit is appended to a per-instance history; `start_m`
    // marks where the current detection attempt began (reset, load, non-overlap match).
    int          pw[3]   = '{4, 4, 8};
    int          cmax[3] = '{255, 3, 255};
    logic [31:0] pdef[3] = '{32'hB, 32'hF, 32'hA5};
    bit          acc[3][8192];
    logic [31:0] patm[3];
    int          cnt_m[3];
    bit          yq_m[3];
    int          start_m[3];
    int          len_m[3];
    bit          exp_y[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit model_match(int k);
        int base;
        if (!en || pat_load) return 1'b0;
        if (len_m[k] - start_m[k] < pw[k] - 1) return 1'b0;
        base = len_m[k] - (pw[k] - 1);
        for (int i = 0; i < pw[k] - 1; i++)
            if (acc[k][base + i] != patm[k][pw[k] - 1 - i]) return 1'b0;
        return x == patm[k][0];
    endfunction

    task automatic step(input bit e, input bit xi, input bit o, input bit ld,
                        input logic [31:0] pin, input bit clr);
        logic [31:0] mask;
        @(negedge clk);
        en = e; x = xi; ovl = o; pat_load = ld; pat_in = pin; cnt_clr = clr;
        #1;
        for (int k = 0; k < 3; k++) exp_y[k] = model_match(k);
        check("y_a", 32'(y_a), 32'(exp_y[0]));
        check("y_b", 32'(y_b), 32'(exp_y[1]));
        check("y_c", 32'(y_c), 32'(exp_y[2]));
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            mask = (pw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << pw[k]) - 32'd1);
            if (ld) begin
                patm[k] = pin & mask;
                start_m[k] = len_m[k];
            end else if (e) begin
                acc[k][len_m[k]] = xi;
                len_m[k]++;
                if (exp_y[k] && !o) start_m[k] = len_m[k];
            end
            yq_m[k] = exp_y[k];
            if (clr) cnt_m[k] = 0;
            else if (exp_y[k] && cnt_m[k] < cmax[k]) cnt_m[k]++;
        end
        #1;
        check("yq_a", 32'(yq_a), 32'(yq_m[0]));
        check("yq_b", 32'(yq_b), 32'(yq_m[1]));
        check("yq_c", 32'(yq_c), 32'(yq_m[2]));
        check("cnt_a", 32'(cnt_a), 32'(cnt_m[0]));
        check("cnt_b", 32'(cnt_b), 32'(cnt_m[1]));
        check("cnt_c", 32'(cnt_c), 32'(cnt_m[2]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            start_m[k] = len_m[k];
            patm[k] = pdef[k];
            cnt_m[k] = 0;
            yq_m[k] = 1'b0;
        end
        check("rst_y_a", 32'(y_a), 32'd0);
        check("rst_yq_a", 32'(yq_a), 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_cnt_b", 32'(cnt_b), 32'd0);
        check("rst_cnt_c", 32'(cnt_c), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input bit o);
        logic [31:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) step(1'b1, b[i], o, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            len_m[k] = 0; start_m[k] = 0; patm[k] = pdef[k]; cnt_m[k] = 0; yq_m[k] = 1'b0;
        end

        // Default overlapping stream
        do_reset();
        send_bits(32'b1011011, 7, 1'b1);
        check("t1_cnt_a", 32'(cnt_a), 32'd2);

        // Non-overlapping mode
        do_reset();
        send_bits(32'b1011011, 7, 1'b0);
        check("t2a_cnt_a", 32'(cnt_a), 32'd1);
        do_reset();
        send_bits(32'b10111011, 8, 1'b0);
        check("t2b_cnt_a", 32'(cnt_a), 32'd2);

        // Gaps with en=0 between every bit
        do_reset();
        begin
            logic [3:0] g;
            g = 4'b1011;
            for (int i = 3; i >= 0; i--) begin
                step(1'b1, g[i], 1'b1, 1'b0, 32'd0, 1'b0);
                if (i != 0) begin
                    step(1'b0, 1'($urandom), 1'b1, 1'b0, 32'd0, 1'b0);
                    step(1'b0, 1'($urandom), 1'b1, 1'b0, 32'd0, 1'b0);
                end
            end
        end
        check("t3_gap_cnt_a", 32'(cnt_a), 32'd1);

        // Reset mid-pattern
        do_reset();
        send_bits(32'b101, 3, 1'b1);
        do_reset();
        send_bits(32'b1, 1, 1'b1);
        check("t3_rst_cnt_a", 32'(cnt_a), 32'd0);
        check("t3_rst_y_a", 32'(yq_a), 32'd0);

        // Pattern load mid-stream; bit in the load cycle is discarded
        do_reset();
        send_bits(32'b10, 2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h6, 1'b0);
        send_bits(32'b0110, 4, 1'b1);
        check("t3_load_cnt_a", 32'(cnt_a), 32'd1);

        // Counter saturation and clear on the 2-bit instance
        do_reset();
        send_bits(32'h3FF, 10, 1'b1);
        check("t4_sat_cnt_b", 32'(cnt_b), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        check("t4_clr_cnt_b", 32'(cnt_b), 32'd0);

        // Random sweep, both modes, then mixed mode with occasional loads
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            for (int i = 0; i < 2000; i++) begin
                bit o, ld;
                o  = (ph == 0) ? 1'b1 : (ph == 1) ? 1'b0 : 1'($urandom);
                ld = (ph == 2) && ($urandom_range(0, 199) == 0);
                step(($urandom_range(0, 7) != 0), 1'($urandom), o, ld,
                     $urandom, ($urandom_range(0, 63) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
